// File: rtl/time_nmr_start.sv
// Temporal N-modular-redundancy start stage: accepts one item and re-emits it
// as a burst of tagged copies (shared ID, per-copy replica index, last flag)
// so that a paired end stage can vote across the copies.
module time_nmr_start #(
    parameter int DataWidth   = 32,
    parameter int IDSize      = 1,
    parameter int MaxReplicas = 3,
    localparam int RepW = $clog2(MaxReplicas),
    localparam int CntW = $clog2(MaxReplicas + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic [CntW-1:0]      replicas_i,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic [DataWidth-1:0] data_o,
    output logic [IDSize-1:0]    id_o,
    output logic [RepW-1:0]      rep_o,
    output logic                 last_o,
    output logic                 valid_o,
    input  logic                 ready_i
);

    logic [DataWidth-1:0] data_q, data_d;
    logic [IDSize-1:0]    id_q,   id_d;
    logic [CntW-1:0]      tgt_q,  tgt_d;
    logic [RepW-1:0]      cnt_q,  cnt_d;
    logic                 busy_q, busy_d;

    logic last_w;
    logic accept_w;
    logic xfer_w;

    // Copies to emit for a newly accepted item: one when replication is off,
    // otherwise the request clamped into the legal range [2, MaxReplicas].
    function automatic logic [CntW-1:0] target_for(input logic en,
                                                    input logic [CntW-1:0] n);
        if (!en) begin
            return CntW'(1);
        end else if (n < CntW'(2)) begin
            return CntW'(2);
        end else if (n > CntW'(MaxReplicas)) begin
            return CntW'(MaxReplicas);
        end else begin
            return n;
        end
    endfunction

    // Handshake decode; ready_o lets a new item in on the cycle the final copy leaves.
    always_comb begin
        last_w   = busy_q && (CntW'(cnt_q) == (tgt_q - CntW'(1)));
        xfer_w   = busy_q && ready_i;
        ready_o  = !busy_q || (xfer_w && last_w);
        accept_w = valid_i && ready_o;
    end

    // Next-state: load a new item, advance the copy counter, or go idle.
    always_comb begin
        data_d = data_q;
        id_d   = id_q;
        tgt_d  = tgt_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (accept_w) begin
            data_d = data_i;
            id_d   = id_q + IDSize'(1);
            tgt_d  = target_for(enable_i, replicas_i);
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (xfer_w) begin
            if (last_w) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q + RepW'(1);
            end
        end
    end

    // Item state register; reset abandons any copies still pending.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
            id_q   <= '0;
            tgt_q  <= CntW'(1);
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            data_q <= data_d;
            id_q   <= id_d;
            tgt_q  <= tgt_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    // Outputs come straight from the held item, so they are stable under backpressure.
    always_comb begin
        valid_o = busy_q;
        data_o  = data_q;
        id_o    = id_q;
        rep_o   = cnt_q;
        last_o  = last_w;
    end

endmodule

// File: tb/tb_time_nmr_start.sv
// Bench for time_nmr_start: a queue of expected output beats is filled on
// every modelled accept and drained on every modelled transfer.
module tb_time_nmr_start;
    localparam int DW = 32;
    localparam int IW = 1;
    localparam int MR = 3;
    localparam int RW = $clog2(MR);
    localparam int CW = $clog2(MR + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, en, vld_in, rdy_in;
    logic [CW-1:0] reps;
    logic [DW-1:0] din;
    logic          ready_o, last_o, valid_o;
    logic [DW-1:0] data_o;
    logic [IW-1:0] id_o;
    logic [RW-1:0] rep_o;

    time_nmr_start #(.DataWidth(DW), .IDSize(IW), .MaxReplicas(MR)) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .replicas_i(reps),
        .data_i(din), .valid_i(vld_in), .ready_o(ready_o),
        .data_o(data_o), .id_o(id_o), .rep_o(rep_o), .last_o(last_o),
        .valid_o(valid_o), .ready_i(rdy_in)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic [IW-1:0] id;
        logic [RW-1:0] rep;
        logic          last;
    } beat_t;

    beat_t q[$];
    int    id_m  = 0;
    bit    live  = 1'b0;
    int    total = 0;
    int    bad   = 0;

    logic          o_valid, o_ready, o_last;
    logic [DW-1:0] o_data;
    logic [IW-1:0] o_id;
    logic [RW-1:0] o_rep;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, sample outputs, compare against the model, advance the model.
    task automatic cycle(input logic r, input logic e, input logic [CW-1:0] n,
                         input logic v, input logic [DW-1:0] d, input logic rd);
        bit exp_rdy, acc;
        int copies, nn;
        @(negedge clk);
        rst = r; en = e; reps = n; vld_in = v; din = d; rdy_in = rd;
        #1;
        o_valid = valid_o; o_ready = ready_o; o_last = last_o;
        o_data = data_o; o_id = id_o; o_rep = rep_o;
        exp_rdy = (q.size() == 0) || (q.size() == 1 && rd);
        if (live) begin
            chk("valid", 64'(o_valid), 64'(q.size() != 0));
            chk("ready", 64'(o_ready), 64'(exp_rdy));
            if (q.size() != 0) begin
                chk("data", 64'(o_data), 64'(q[0].d));
                chk("id",   64'(o_id),   64'(q[0].id));
                chk("rep",  64'(o_rep),  64'(q[0].rep));
                chk("last", 64'(o_last), 64'(q[0].last));
            end else begin
                chk("last_idle", 64'(o_last), 64'(0));
            end
        end
        if (r) begin
            q.delete();
            id_m = 0;
            live = 1'b1;
        end else if (live) begin
            acc = v && exp_rdy;
            if (q.size() != 0 && rd) void'(q.pop_front());
            if (acc) begin
                nn = int'(n);
                copies = !e ? 1 : (nn < 2 ? 2 : (nn > MR ? MR : nn));
                id_m = (id_m + 1) % (1 << IW);
                for (int k = 0; k < copies; k++)
                    q.push_back('{d, IW'(id_m), RW'(k), (k == copies - 1)});
            end
        end
    endtask

    // Count copies after an accept, holding ready_i high; bounded.
    task automatic count_copies(input logic e, output int c);
        c = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, e, CW'(3), 1'b0, '0, 1'b1);
            if (o_valid) c++;
            if (o_valid && o_last) return;
        end
        total++; bad++;
        $display("FAIL copy_count_timeout: no last copy within 12 cycles");
    endtask

    int c;

    initial begin
        rst = 1'b1; en = 1'b0; reps = '0; vld_in = 1'b0; din = '0; rdy_in = 1'b0;
        cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);

        // Reset state
        cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        chk("rst_valid", 64'(o_valid), 64'(0));
        chk("rst_ready", 64'(o_ready), 64'(1));
        chk("rst_id",    64'(o_id),    64'(0));
        chk("rst_data",  64'(o_data),  64'(0));
        chk("rst_rep",   64'(o_rep),   64'(0));
        chk("rst_last",  64'(o_last),  64'(0));

        // Three copies of 0xA5
        cycle(1'b0, 1'b1, CW'(3), 1'b1, 32'hA5, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, CW'(3), 1'b0, '0, 1'b1);
            chk("a5_data",  64'(o_data),  64'h0A5);
            chk("a5_id",    64'(o_id),    64'(1));
            chk("a5_rep",   64'(o_rep),   64'(i));
            chk("a5_last",  64'(o_last),  64'(i == 2));
            chk("a5_ready", 64'(o_ready), 64'(i == 2));
        end

        // Replication off: back-to-back single copies, ids alternate 1,0,1,0
        cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            cycle(1'b0, 1'b0, '0, (i <= 4), DW'(i), 1'b1);
            if (i >= 2) begin
                chk("b2b_valid", 64'(o_valid), 64'(1));
                chk("b2b_data",  64'(o_data),  64'(i - 1));
                chk("b2b_id",    64'(o_id),    64'((i - 1) & 1));
                chk("b2b_last",  64'(o_last),  64'(1));
            end
        end

        // Clamping: full-scale request -> MR copies, 0 or 1 -> 2 copies
        cycle(1'b0, 1'b1, '1, 1'b1, 32'h31, 1'b1);
        count_copies(1'b1, c);
        chk("clamp_hi", 64'(c), 64'(3));
        cycle(1'b0, 1'b1, CW'(0), 1'b1, 32'h30, 1'b1);
        count_copies(1'b1, c);
        chk("clamp_0", 64'(c), 64'(2));
        cycle(1'b0, 1'b1, CW'(1), 1'b1, 32'h301, 1'b1);
        count_copies(1'b1, c);
        chk("clamp_1", 64'(c), 64'(2));

        // Backpressure on copy 1
        cycle(1'b0, 1'b1, CW'(3), 1'b1, 32'h32, 1'b1);
        cycle(1'b0, 1'b1, CW'(3), 1'b0, '0, 1'b1);
        chk("bp_rep0", 64'(o_rep), 64'(0));
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, CW'(3), 1'b1, 32'hDEAD, 1'b0);
            chk("bp_hold_rep",   64'(o_rep),   64'(1));
            chk("bp_hold_data",  64'(o_data),  64'h32);
            chk("bp_hold_ready", 64'(o_ready), 64'(0));
            chk("bp_hold_last",  64'(o_last),  64'(0));
        end
        cycle(1'b0, 1'b1, CW'(3), 1'b0, '0, 1'b1);
        chk("bp_rel_rep1",  64'(o_rep),   64'(1));
        chk("bp_rel_ready", 64'(o_ready), 64'(0));
        cycle(1'b0, 1'b1, CW'(3), 1'b0, '0, 1'b1);
        chk("bp_rel_rep2",  64'(o_rep),   64'(2));
        chk("bp_rel_last",  64'(o_last),  64'(1));
        chk("bp_rel_rdy2",  64'(o_ready), 64'(1));

        // enable_i dropped mid-item does not shorten it; next item gets one copy
        cycle(1'b0, 1'b1, CW'(3), 1'b1, 32'h33, 1'b1);
        count_copies(1'b0, c);
        chk("en_toggle_cur", 64'(c), 64'(3));
        cycle(1'b0, 1'b0, CW'(3), 1'b1, 32'h133, 1'b1);
        count_copies(1'b0, c);
        chk("en_toggle_next", 64'(c), 64'(1));

        // Reset while rep_o=1 abandons the item and restarts the ID sequence
        cycle(1'b0, 1'b1, CW'(3), 1'b1, 32'h34, 1'b1);
        cycle(1'b0, 1'b1, CW'(3), 1'b0, '0, 1'b1);
        cycle(1'b1, 1'b1, CW'(3), 1'b0, '0, 1'b1);
        chk("mid_rst_rep", 64'(o_rep), 64'(1));
        cycle(1'b0, 1'b1, CW'(3), 1'b1, 32'h35, 1'b1);
        chk("post_rst_valid", 64'(o_valid), 64'(0));
        chk("post_rst_ready", 64'(o_ready), 64'(1));
        chk("post_rst_id",    64'(o_id),    64'(0));
        cycle(1'b0, 1'b1, CW'(3), 1'b0, '0, 1'b1);
        chk("post_rst_new_id",   64'(o_id),   64'(1));
        chk("post_rst_new_data", 64'(o_data), 64'h35);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 99) == 0), 1'($urandom),
                  CW'($urandom_range(0, (1 << CW) - 1)),
                  ($urandom_range(0, 3) != 0), DW'($urandom),
                  ($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
